// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, opcodes and sequencer states for the regfile client
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 8;
  localparam int ADDR_W = $clog2(NREGS);
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_MOV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10
  } state_e;

endpackage

// File: rtl/regfile_alu.sv
// rtl/regfile_alu.sv - combinational ALU; add/sub wrap modulo 2^DATA_W
module regfile_alu
  import regfile_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_MOV:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// rtl/regfile_op_sequencer.sv - reads two registers, applies an op, writes the result back
module regfile_op_sequencer
  import regfile_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst_s,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [AW-1:0] cmd_rd,
  output logic [AW-1:0] rf_raddr_1,
  output logic [AW-1:0] rf_raddr_2,
  input  logic [DW-1:0] rf_rdata_1,
  input  logic [DW-1:0] rf_rdata_2,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          done,
  output logic [DW-1:0] result,
  output logic [CW-1:0] op_count
);

  state_e        state;
  op_e           op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] alu_y;

  regfile_alu #(.W(DW)) u_alu (
    .op (op_q),
    .a  (rf_rdata_1),
    .b  (rf_rdata_2),
    .y  (alu_y)
  );

  // cmd_ready stays low out of reset until the first edge in IDLE
  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      state      <= S_IDLE;
      op_q       <= OP_ADD;
      rd_q       <= '0;
      cmd_ready  <= 1'b0;
      rf_raddr_1 <= '0;
      rf_raddr_2 <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      done       <= 1'b0;
      result     <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q       <= op_e'(cmd_op);
            rd_q       <= cmd_rd;
            rf_raddr_1 <= cmd_rs1;
            rf_raddr_2 <= cmd_rs2;
            cmd_ready  <= 1'b0;
            state      <= S_READ;
          end else begin
            cmd_ready  <= 1'b1;
          end
        end
        S_READ: begin
          rf_wdata <= alu_y;
          rf_waddr <= rd_q;
          rf_we    <= 1'b1;
          done     <= 1'b1;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          rf_we     <= 1'b0;
          done      <= 1'b0;
          result    <= rf_wdata;
          if (op_count != {CW{1'b1}})
            op_count <= op_count + 1'b1;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          rf_we     <= 1'b0;
          done      <= 1'b0;
          cmd_ready <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb/tb_regfile_op_sequencer.sv - scoreboard bench: sequencer driving an 8x32 regfile model
module tb_regfile_op_sequencer;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_s = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
  logic [2:0]  rf_raddr_1, rf_raddr_2, rf_waddr;
  logic [31:0] rf_rdata_1, rf_rdata_2, rf_wdata, result;
  logic        rf_we, done;
  logic [15:0] op_count;

  logic [31:0] rf_mem [8];
  logic [31:0] shadow [8];
  logic        tb_we = 1'b0;
  logic [2:0]  tb_waddr = '0;
  logic [31:0] tb_wdata = '0;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [15:0] count;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_count = '0;

  always #5 clk = ~clk;

  regfile_op_sequencer dut (
    .clk        (clk),
    .rst_s      (rst_s),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_rd     (cmd_rd),
    .rf_raddr_1 (rf_raddr_1),
    .rf_raddr_2 (rf_raddr_2),
    .rf_rdata_1 (rf_rdata_1),
    .rf_rdata_2 (rf_rdata_2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .done       (done),
    .result     (result),
    .op_count   (op_count)
  );

  // register file responder: combinational reads, sequencer write has priority
  assign rf_rdata_1 = rf_mem[rf_raddr_1];
  assign rf_rdata_2 = rf_mem[rf_raddr_2];
  always @(posedge clk) begin
    if (rf_we)      rf_mem[rf_waddr] <= rf_wdata;
    else if (tb_we) rf_mem[tb_waddr] <= tb_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic seed(input logic [2:0] addr, input logic [31:0] val);
    tb_we = 1'b1; tb_waddr = addr; tb_wdata = val;
    @(posedge clk);
    @(negedge clk);
    tb_we = 1'b0;
    shadow[addr] = val;
  endtask

  task automatic issue(input op_e op, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input logic [31:0] exp, input bit hold);
    int n;
    int low;
    exp_t e;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", {31'b0, cmd_ready}, 32'd1);
      return;
    end
    exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'd1;
    e.addr = rd; e.data = exp; e.count = exp_count;
    exp_q.push_back(e);
    shadow[rd] = exp;
    cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    low = 0;
    while (!cmd_ready && low < 10) begin low++; @(negedge clk); end
    cmd_valid = 1'b0;
    chk("ready_low_cycles", low, 32'd2);
  endtask

  // monitor: write-port checks on the WRITE cycle, result/op_count one cycle later
  initial begin
    exp_t e;
    exp_t last;
    bit pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("result", result, last.data);
        chk("op_count", {16'b0, op_count}, {16'b0, last.count});
        pend = 1'b0;
      end
      if (rf_we || done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {31'b0, rf_we}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("waddr", {29'b0, rf_waddr}, {29'b0, e.addr});
          chk("wdata", rf_wdata, e.data);
          chk("done_with_we", {30'b0, done, rf_we}, 32'd3);
          last = e;
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf_mem[i] = 32'd0;
      shadow[i] = 32'd0;
    end

    // reset
    repeat (2) begin
      @(negedge clk);
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
      chk("rst_op_count", {16'b0, op_count}, 32'd0);
    end
    rst_s = 1'b0;
    #1 chk("ready_before_edge", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_release", {31'b0, cmd_ready}, 32'd1);

    // basic add
    seed(3'd1, 32'd5);
    seed(3'd2, 32'd3);
    issue(OP_ADD, 3'd1, 3'd2, 3'd4, 32'd8, 1'b0);

    // wraparound add and sub
    seed(3'd1, 32'hFFFF_FFFF);
    seed(3'd2, 32'd1);
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 32'h0000_0000, 1'b0);
    issue(OP_SUB, 3'd2, 3'd1, 3'd5, 32'h0000_0002, 1'b0);

    // back-to-back dependency through r6
    seed(3'd1, 32'h0000_0010);
    seed(3'd2, 32'h0000_000F);
    seed(3'd6, 32'h0000_0000);
    issue(OP_ADD, 3'd1, 3'd2, 3'd6, 32'h0000_001F, 1'b0);
    issue(OP_AND, 3'd6, 3'd2, 3'd7, 32'h0000_000F, 1'b0);

    // self-destination with cmd_valid held through WRITE
    issue(OP_SUB, 3'd1, 3'd1, 3'd1, 32'h0000_0000, 1'b1);
    issue(OP_MOV, 3'd6, 3'd3, 3'd0, 32'h0000_001F, 1'b0);
    @(negedge clk);
    chk("result_before_abort", result, 32'h0000_001F);

    // reset during READ aborts the write
    cmd_op = OP_ADD; cmd_rs1 = 3'd6; cmd_rs2 = 3'd7; cmd_rd = 3'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_s = 1'b1;
    #1 chk("abort_rf_we", {31'b0, rf_we}, 32'd0);
    @(negedge clk);
    chk("abort_rf_we_held", {31'b0, rf_we}, 32'd0);
    chk("abort_op_count", {16'b0, op_count}, 32'd0);
    chk("abort_result", result, 32'd0);
    rst_s = 1'b0;
    exp_count = '0;
    @(negedge clk);
    chk("ready_after_abort", {31'b0, cmd_ready}, 32'd1);

    issue(OP_ADD, 3'd6, 3'd7, 3'd2, 32'h0000_002E, 1'b0);
    repeat (3) @(negedge clk);

    chk("queue_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("reg%0d", i), rf_mem[i], shadow[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
